spi_tx_serializer: RTL and testbench
====================================

SPI_TX_SERIALIZER -- requirements
Module: spi_tx_serializer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, SYS_CLK cycles per TX_CLK half-period (legal range 1..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, word buffer depth (power of two, minimum 4).
REQ-003 SHALL have port SYS_CLK input 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port RST input 1: synchronous, active-low reset.
REQ-005 SHALL have port DATA input 16: big-endian word from the Cypress slave-FIFO reader.
REQ-006 SHALL have port ENA input 1: DATA valid strobe, one word per high cycle.
REQ-007 SHALL have port BUSY output 1: buffer almost full; upstream stops issuing ENA.
REQ-008 SHALL have port OVERFLOW output 1: sticky flag, a word was dropped.
REQ-009 SHALL have port TX_CLK output 1: generated line clock, idle low.
REQ-010 SHALL have port TX_DATA output 1: serial data, MSB first.
REQ-011 SHALL have port TX_LOAD output 1: high for every bit of every transmitted byte.
REQ-012 SHALL have port TX_STOP output 1: end-of-message marker.

Function
REQ-013 SHALL write DATA into the word buffer on every cycle ENA=1 and the buffer is not full.
REQ-014 SHALL drop the word and set OVERFLOW on ENA=1 with a full buffer; OVERFLOW clears only on reset.
REQ-015 SHALL assert BUSY (registered) while buffer count >= FIFO_DEPTH-2.
REQ-016 SHALL honour a simultaneous write and pop in the same cycle; count unchanged.
REQ-017 SHALL treat the first word of a message as a header: bits [7:0] = payload byte count N; bits [15:8] ignored.
REQ-018 SHALL follow the header with ceil(N/2) payload words; high byte sent before low byte; for odd N, the last word's low byte is discarded.
REQ-019 SHALL consume an N=0 header with no line activity and return to IDLE.
REQ-020 SHALL run FSM states IDLE -> HEADER -> LOAD -> SHIFT -> (LOAD | STOP) -> GAP -> IDLE.
REQ-021 SHALL generate a tick every CLK_DIV cycles only outside IDLE/HEADER; each bit = two ticks, TX_CLK low then high; TX_DATA changes only while TX_CLK falls or is low.
REQ-022 SHALL hold TX_LOAD high over all 8 bit periods of each byte and low between bytes for 0 extra bit periods (back-to-back) when data is available.
REQ-023 SHALL assert TX_STOP for exactly one bit period after the last byte, TX_LOAD low, TX_DATA low.
REQ-024 SHALL hold GAP for 2 bit periods with all line outputs low before accepting the next header.
REQ-025 SHALL stall in LOAD on buffer empty mid-message: TX_CLK low, TX_LOAD low, tick counter held; resume without loss when data arrives.
REQ-026 SHALL start the first bit (TX_LOAD=1) no later than 4 SYS_CLK cycles after the first payload word is written while IDLE with the header already buffered.

Reset
REQ-027 SHALL on RST=0 at a clock edge: flush buffer, FSM to IDLE, clear counters, BUSY=0, OVERFLOW=0, TX_CLK=0, TX_DATA=0, TX_LOAD=0, TX_STOP=0.
REQ-028 SHALL abort any in-flight message on reset mid-operation, with no partial byte after release.
REQ-029 SHALL ignore ENA during the reset cycle.

Structure
REQ-030 SHALL place the FSM state type, header field positions (LEN_LSB=0, LEN_MSB=7) and parameter defaults in shared package spi_tx_pkg.
REQ-031 SHALL implement the word buffer as sub-module word_fifo (synchronous, show-ahead, count output).

Verification
REQ-032 Header 0x0002 + word 0xA55A, CLK_DIV=4 -> TX_DATA 10100101 then 01011010, TX_LOAD high 16 bit periods, one TX_STOP period, each bit 8 SYS_CLK.
REQ-033 Header 0x0003 + 0x1234, 0x56FF -> bytes 0x12, 0x34, 0x56 sent; 0xFF never appears; TX_STOP after 3rd byte.
REQ-034 Header 0x0000 followed by header 0x0001 + 0x8000 -> first message produces no TX_LOAD/TX_STOP; second sends 0x80.
REQ-035 18 ENA words with FIFO_DEPTH=16, line stalled -> BUSY high at count 14, words 17-18 dropped, OVERFLOW=1.
REQ-036 Header 0x0004 + 0xDEAD, delay 50 cycles, then 0xBEEF -> TX_CLK held low during stall, output 0xDE 0xAD 0xBE 0xEF intact.
REQ-037 RST=0 during bit 3 of byte 2 -> all outputs 0 next cycle; after release, new message 0x0001 + 0x7F00 sends only 0x7F.

Source files
------------

// File: rtl/spi_tx_pkg.sv
// rtl/spi_tx_pkg.sv - shared types, field positions and defaults for the SPI TX serializer
// Contents:
//   state_t             serializer FSM states
//   LEN_LSB / LEN_MSB   header byte-count field position
//   *_DEFAULT           parameter defaults for spi_tx_serializer
//   word_bits()         bits to shift for the next payload word
package spi_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LOAD,
    SHIFT,
    STOP,
    GAP
  } state_t;

  localparam int WORD_W             = 16;
  localparam int LEN_LSB            = 0;
  localparam int LEN_MSB            = 7;
  localparam int CLK_DIV_DEFAULT    = 4;
  localparam int FIFO_DEPTH_DEFAULT = 16;
  localparam int GAP_BITS           = 2;
  localparam int GAP_TICKS          = 2 * GAP_BITS;

  // A word carries two bytes unless only one byte of the message is left,
  // in which case its low byte is discarded.
  function automatic logic [4:0] word_bits(input logic [7:0] remaining);
    return (remaining >= 8'd2) ? 5'd16 : 5'd8;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - synchronous show-ahead word buffer with occupancy count
// Ports:
//   clk      in   clock, rising edge
//   resetn   in   synchronous active-low reset, flushes the buffer
//   wr_en    in   write strobe; ignored while full
//   wr_data  in   word to write
//   rd_en    in   pop strobe; ignored while empty
//   rd_data  out  oldest word, valid whenever empty is low
//   count    out  words currently held
//   full     out  count == DEPTH
//   empty    out  count == 0
module word_fifo
  import spi_tx_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int WIDTH = WORD_W,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_tx_serializer.sv
// rtl/spi_tx_serializer.sv - buffers header/payload words and shifts them out as a clocked serial line
// Ports:
//   SYS_CLK   in   single clock, rising edge
//   RST       in   synchronous active-low reset
//   DATA      in   16-bit big-endian word from the slave-FIFO reader
//   ENA       in   DATA valid, one word per high cycle
//   BUSY      out  buffer almost full (registered), upstream should pause
//   OVERFLOW  out  sticky: a word arrived while the buffer was full
//   TX_CLK    out  line clock, idle low, low then high within each bit
//   TX_DATA   out  serial data, MSB first, changes only with TX_CLK low
//   TX_LOAD   out  high for every bit of every byte
//   TX_STOP   out  one bit period after the last byte of a message
module spi_tx_serializer
  import spi_tx_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic [15:0] DATA,
  input  logic        ENA,
  output logic        BUSY,
  output logic        OVERFLOW,
  output logic        TX_CLK,
  output logic        TX_DATA,
  output logic        TX_LOAD,
  output logic        TX_STOP
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   rd_data;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  state_t        state;
  logic [7:0]    div_cnt;
  logic          phase;      // 0: low half of a bit, 1: high half
  logic [4:0]    bits_left;  // bits of the current word still to finish
  logic [7:0]    remaining;  // payload bytes not yet fetched from the buffer
  logic [14:0]   sreg;       // bits queued behind TX_DATA
  logic [2:0]    gap_ticks;
  logic          running;
  logic          tick;
  logic          word_end;

  word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (SYS_CLK),
    .resetn  (RST),
    .wr_en   (push),
    .wr_data (DATA),
    .rd_en   (pop),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    running  = (state == SHIFT) || (state == STOP) || (state == GAP);
    tick     = running && (div_cnt == 8'(CLK_DIV - 1));
    word_end = (state == SHIFT) && tick && phase && (bits_left == 5'd1);
    push     = ENA && !full;
    // Pop the header in IDLE; pop payload from LOAD, or directly at a word
    // boundary so consecutive words go out with no break in TX_LOAD.
    pop      = !empty && ((state == IDLE) || (state == LOAD) ||
                          (word_end && (remaining != 8'd0)));
    count_next = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
  end

  always_ff @(posedge SYS_CLK) begin
    if (!RST) begin
      state     <= IDLE;
      div_cnt   <= '0;
      phase     <= 1'b0;
      bits_left <= '0;
      remaining <= '0;
      sreg      <= '0;
      gap_ticks <= '0;
      BUSY      <= 1'b0;
      OVERFLOW  <= 1'b0;
      TX_CLK    <= 1'b0;
      TX_DATA   <= 1'b0;
      TX_LOAD   <= 1'b0;
      TX_STOP   <= 1'b0;
    end else begin
      BUSY <= (count_next >= CW'(FIFO_DEPTH - 2));
      if (ENA && full) OVERFLOW <= 1'b1;

      // The divider is held (not cleared) in LOAD so a stall never shortens
      // or stretches a half-period; it always sits at zero on a word boundary.
      if (running) div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
      else if (state != LOAD) div_cnt <= 8'd0;

      case (state)
        IDLE: begin
          phase <= 1'b0;
          if (pop) begin
            remaining <= rd_data[LEN_MSB:LEN_LSB];
            state     <= HEADER;
          end
        end
        HEADER: state <= (remaining == 8'd0) ? IDLE : LOAD;
        LOAD: begin
        end
        SHIFT: begin
          if (tick) begin
            if (!phase) begin
              TX_CLK <= 1'b1;
              phase  <= 1'b1;
            end else begin
              TX_CLK <= 1'b0;
              phase  <= 1'b0;
              if (bits_left != 5'd1) begin
                bits_left <= bits_left - 5'd1;
                sreg      <= {sreg[13:0], 1'b0};
                TX_DATA   <= sreg[14];
              end else if (remaining == 8'd0) begin
                state   <= STOP;
                TX_LOAD <= 1'b0;
                TX_DATA <= 1'b0;
                TX_STOP <= 1'b1;
              end else if (empty) begin
                state   <= LOAD;
                TX_LOAD <= 1'b0;
                TX_DATA <= 1'b0;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (!phase) begin
              TX_CLK <= 1'b1;
              phase  <= 1'b1;
            end else begin
              TX_CLK    <= 1'b0;
              phase     <= 1'b0;
              TX_STOP   <= 1'b0;
              gap_ticks <= '0;
              state     <= GAP;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (gap_ticks == 3'(GAP_TICKS - 1)) begin
              gap_ticks <= '0;
              state     <= IDLE;
            end else begin
              gap_ticks <= gap_ticks + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Payload word fetch: first bit is presented with TX_CLK low.
      if (pop && (state != IDLE)) begin
        sreg      <= rd_data[14:0];
        TX_DATA   <= rd_data[15];
        TX_LOAD   <= 1'b1;
        TX_CLK    <= 1'b0;
        phase     <= 1'b0;
        bits_left <= word_bits(remaining);
        remaining <= (remaining >= 8'd2) ? remaining - 8'd2 : remaining - 8'd1;
        state     <= SHIFT;
      end
    end
  end

endmodule

// File: tb/tb_spi_tx_serializer.sv
// tb/tb_spi_tx_serializer.sv - self-checking bench for spi_tx_serializer
module tb_spi_tx_serializer;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int BIT_CYC    = 2 * CLK_DIV;
  localparam int STOP_MARK  = 256;

  logic        SYS_CLK = 1'b0;
  logic        RST     = 1'b0;
  logic        ENA     = 1'b0;
  logic [15:0] DATA    = '0;
  logic        BUSY, OVERFLOW, TX_CLK, TX_DATA, TX_LOAD, TX_STOP;

  int checks = 0;
  int errors = 0;

  int exp_bytes[$];
  int got_bytes[$];
  bit in_msg    = 1'b0;
  int bytes_left = 0;
  bit exp_ovf   = 1'b0;

  bit         mon_en = 1'b0;
  bit         p_clk, p_load, p_stop, p_data;
  int         bitcnt, low_run, high_run, since_stop;
  bit         seen_stop;
  logic [7:0] cur;
  int         load_cyc, load_rises, stop_cyc;

  spi_tx_serializer #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .SYS_CLK  (SYS_CLK),
    .RST      (RST),
    .DATA     (DATA),
    .ENA      (ENA),
    .BUSY     (BUSY),
    .OVERFLOW (OVERFLOW),
    .TX_CLK   (TX_CLK),
    .TX_DATA  (TX_DATA),
    .TX_LOAD  (TX_LOAD),
    .TX_STOP  (TX_STOP)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Message parser: header gives N, then ceil(N/2) words, high byte first.
  function automatic void model_word(input logic [15:0] w);
    if (!in_msg) begin
      if (w[7:0] != 8'd0) begin
        in_msg     = 1'b1;
        bytes_left = int'(w[7:0]);
      end
    end else begin
      exp_bytes.push_back(int'(w[15:8]));
      bytes_left--;
      if (bytes_left > 0) begin
        exp_bytes.push_back(int'(w[7:0]));
        bytes_left--;
      end
      if (bytes_left == 0) begin
        exp_bytes.push_back(STOP_MARK);
        in_msg = 1'b0;
      end
    end
  endfunction

  // Line monitor: decodes bytes and stop markers, checks line rules every cycle.
  always @(negedge SYS_CLK) begin
    if (mon_en) begin
      int e;
      check("overflow", OVERFLOW, exp_ovf);
      if (!TX_LOAD && !TX_STOP) check("inactive_line_low", {TX_CLK, TX_DATA}, 0);
      if (TX_STOP) check("stop_load_data_low", {TX_LOAD, TX_DATA}, 0);
      if (p_clk && TX_CLK) check("data_stable_clk_high", TX_DATA, p_data);
      if (p_clk && !TX_CLK) begin
        check("high_half_len", high_run, CLK_DIV);
        high_run = 0;
        low_run  = 0;
      end
      if (!p_clk && TX_CLK) begin
        check("low_half_len", low_run, CLK_DIV);
        low_run = 0;
        if (TX_LOAD) begin
          cur = {cur[6:0], TX_DATA};
          bitcnt++;
          if (bitcnt == 8) begin
            bitcnt = 0;
            got_bytes.push_back(int'(cur));
            e = (exp_bytes.size() != 0) ? exp_bytes.pop_front() : -1;
            check("byte", int'(cur), e);
          end
        end
      end
      if (TX_CLK) high_run++;
      else if (TX_LOAD || TX_STOP) low_run++;
      else low_run = 0;
      if (TX_STOP && !p_stop) begin
        e = (exp_bytes.size() != 0) ? exp_bytes.pop_front() : -1;
        check("stop_marker", e, STOP_MARK);
        check("stop_on_byte_boundary", bitcnt, 0);
      end
      if (!TX_STOP && p_stop) begin
        seen_stop  = 1'b1;
        since_stop = 0;
      end
      since_stop++;
      if (p_load && !TX_LOAD) check("load_fall_byte_boundary", bitcnt, 0);
      if (!p_load && TX_LOAD) begin
        load_rises++;
        if (seen_stop) check("gap_at_least_two_bits", int'(since_stop > 2 * BIT_CYC), 1);
        seen_stop = 1'b0;
      end
      if (TX_LOAD) load_cyc++;
      if (TX_STOP) stop_cyc++;
      p_clk  = TX_CLK;
      p_load = TX_LOAD;
      p_stop = TX_STOP;
      p_data = TX_DATA;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge SYS_CLK);
    #1;
  endtask

  task automatic put(input logic [15:0] w, input bit accept);
    @(negedge SYS_CLK);
    DATA = w;
    ENA  = 1'b1;
    @(posedge SYS_CLK);
    #1;
    ENA = 1'b0;
    if (accept) model_word(w);
  endtask

  task automatic put_flow(input logic [15:0] w);
    for (int i = 0; i < 5000 && BUSY; i++) begin
      @(posedge SYS_CLK);
      #1;
    end
    if (BUSY) check("busy_release", BUSY, 0);
    put(w, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20000 && exp_bytes.size() != 0; i++) @(posedge SYS_CLK);
    check("drain_done", exp_bytes.size(), 0);
    idle(4 * BIT_CYC);
  endtask

  task automatic clear_stats();
    got_bytes.delete();
    load_cyc   = 0;
    load_rises = 0;
    stop_cyc   = 0;
  endtask

  task automatic check_got(input string name, input int n,
                           input int b0, input int b1, input int b2, input int b3);
    int e[4];
    e = '{b0, b1, b2, b3};
    check({name, "_count"}, got_bytes.size(), n);
    for (int i = 0; i < n; i++)
      check({name, "_byte"}, (i < got_bytes.size()) ? got_bytes[i] : -1, e[i]);
  endtask

  task automatic clear_monitor();
    exp_bytes.delete();
    in_msg     = 1'b0;
    bytes_left = 0;
    exp_ovf    = 1'b0;
    bitcnt     = 0;
    low_run    = 0;
    high_run   = 0;
    seen_stop  = 1'b0;
    p_clk      = 1'b0;
    p_load     = 1'b0;
    p_stop     = 1'b0;
    p_data     = 1'b0;
  endtask

  initial begin
    int n, lat;
    logic [15:0] w;

    clear_monitor();
    clear_stats();
    idle(3);
    check("reset_busy", BUSY, 0);
    check("reset_overflow", OVERFLOW, 0);
    check("reset_tx_clk", TX_CLK, 0);
    check("reset_tx_data", TX_DATA, 0);
    check("reset_tx_load", TX_LOAD, 0);
    check("reset_tx_stop", TX_STOP, 0);
    RST = 1'b1;
    idle(2);
    mon_en = 1'b1;

    // Two-byte message: 0xA5 then 0x5A, one unbroken 16-bit load window.
    clear_stats();
    put(16'h0002, 1'b1);
    put(16'hA55A, 1'b1);
    drain();
    check_got("msg_a55a", 2, 'hA5, 'h5A, 0, 0);
    check("msg_a55a_load_cycles", load_cyc, 16 * BIT_CYC);
    check("msg_a55a_load_rises", load_rises, 1);
    check("msg_a55a_stop_cycles", stop_cyc, BIT_CYC);

    // Odd length: low byte of the last word never leaves.
    clear_stats();
    put(16'h0003, 1'b1);
    put(16'h1234, 1'b1);
    put(16'h56FF, 1'b1);
    drain();
    check_got("msg_odd", 3, 'h12, 'h34, 'h56, 0);
    check("msg_odd_load_cycles", load_cyc, 24 * BIT_CYC);
    check("msg_odd_load_rises", load_rises, 1);
    check("msg_odd_stop_cycles", stop_cyc, BIT_CYC);

    // Empty message, then one byte whose payload arrives late.
    clear_stats();
    put(16'h0000, 1'b1);
    put(16'h0001, 1'b1);
    idle(10);
    check("zero_len_no_load", TX_LOAD, 0);
    put(16'h8000, 1'b1);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(posedge SYS_CLK);
      #1;
      if (TX_LOAD) lat = i;
    end
    check("first_bit_latency_ok", int'(lat >= 1 && lat <= 4), 1);
    drain();
    check_got("msg_80", 1, 'h80, 0, 0, 0);
    check("msg_80_stop_cycles", stop_cyc, BIT_CYC);

    // Mid-message stall: second word arrives 50 cycles after the first drains.
    clear_stats();
    put(16'h0004, 1'b1);
    put(16'hDEAD, 1'b1);
    for (int i = 0; i < 1000 && got_bytes.size() < 2; i++) @(posedge SYS_CLK);
    idle(50);
    check("stall_tx_clk_low", TX_CLK, 0);
    check("stall_tx_load_low", TX_LOAD, 0);
    put(16'hBEEF, 1'b1);
    drain();
    check_got("msg_stall", 4, 'hDE, 'hAD, 'hBE, 'hEF);
    check("msg_stall_load_rises", load_rises, 2);

    // Overflow: line busy on a long word, then 18 back-to-back writes.
    clear_stats();
    put(16'h00FF, 1'b1);
    put(16'h0102, 1'b1);
    for (int i = 0; i < 50 && !TX_LOAD; i++) begin
      @(posedge SYS_CLK);
      #1;
    end
    check("ovf_line_started", TX_LOAD, 1);
    for (int k = 1; k <= 18; k++) begin
      w = 16'($urandom);
      put(w, k <= FIFO_DEPTH);
      if (k > FIFO_DEPTH) exp_ovf = 1'b1;
      check($sformatf("busy_after_write_%0d", k), BUSY, int'(k >= FIFO_DEPTH - 2));
    end
    check("overflow_sticky", OVERFLOW, 1);

    // Reset during bit 3 of byte 2; a header offered during reset is ignored.
    for (int i = 0; i < 2000 && !(got_bytes.size() == 1 && bitcnt == 3); i++) @(posedge SYS_CLK);
    check("reached_byte2_bit3", int'(got_bytes.size() == 1 && bitcnt == 3), 1);
    @(negedge SYS_CLK);
    RST  = 1'b0;
    ENA  = 1'b1;
    DATA = 16'h0005;
    @(posedge SYS_CLK);
    #1;
    clear_monitor();
    clear_stats();
    check("rst_outputs_low", {BUSY, OVERFLOW, TX_CLK, TX_DATA, TX_LOAD, TX_STOP}, 0);
    @(negedge SYS_CLK);
    ENA = 1'b0;
    RST = 1'b1;
    idle(3);
    put(16'h0001, 1'b1);
    put(16'h7F00, 1'b1);
    drain();
    check_got("after_reset", 1, 'h7F, 0, 0, 0);

    // Random messages with random pacing, honouring BUSY.
    clear_stats();
    for (int m = 0; m < 12; m++) begin
      n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40));
      w = {8'($urandom), 8'(n)};
      put_flow(w);
      for (int i = 0; i < (n + 1) / 2; i++) begin
        if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(20, 60)));
        else idle(int'($urandom_range(0, 2)));
        put_flow(16'($urandom));
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
